// File: rtl/gray_rx_decoder.sv
// -----------------------------------------------------------------------------
// gray_rx_decoder
//
// Receives a gray-coded count that may come from another clock domain,
// re-times it through a two-flop synchronizer and decodes it to binary.
// The decode stage registers the new binary value and its step relative to
// the previous value. It also raises a sticky error when the accepted gray
// value differs from the last accepted one in more than one bit.
//
// Ports
//   clk        in   single rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   gray_i     in   [WIDTH] gray-coded count (possibly asynchronous)
//   en_i       in   decode-stage update enable
//   clr_err_i  in   synchronous clear of err_o
//   bin_o      out  [WIDTH] registered binary value of the accepted gray code
//   bin_vld_o  out  one-cycle pulse when bin_o takes a new value
//   step_o     out  [WIDTH] registered (bin_new - bin_old) mod 2^WIDTH
//   err_o      out  sticky flag for a multi-bit gray transition
// -----------------------------------------------------------------------------
module gray_rx_decoder #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             en_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             bin_vld_o,
  output logic [WIDTH-1:0] step_o,
  output logic             err_o
);

  // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [WIDTH-1:0] f_gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b            = '0;
    b[WIDTH-1]   = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  // True when more than one bit of d is set (clearing the lowest set bit
  // leaves something behind).
  function automatic logic f_multi_bit(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] one;
    one = {{(WIDTH-1){1'b0}}, 1'b1};
    return ((d & (d - one)) != '0);
  endfunction

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev_gray;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_step;
  logic             r_bin_vld;
  logic             r_err;

  logic             w_accept;
  logic [WIDTH-1:0] w_bin_new;
  logic [WIDTH-1:0] w_step;
  logic             w_multi;

  // Decode-stage next-value logic; the step is measured against the
  // currently held binary value, so any changes skipped while en_i was low
  // collapse into one step.
  always_comb begin
    w_accept  = 1'b0;
    w_bin_new = f_gray2bin(r_sync2);
    w_step    = w_bin_new - r_bin;
    w_multi   = f_multi_bit(r_sync2 ^ r_prev_gray);
    if (en_i && (r_sync2 != r_prev_gray)) begin
      w_accept = 1'b1;
    end else begin
      w_accept = 1'b0;
    end
  end

  // Two-flop synchronizer, clocked every cycle independent of en_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= {WIDTH{1'b0}};
      r_sync2 <= {WIDTH{1'b0}};
    end else begin
      r_sync1 <= gray_i;
      r_sync2 <= r_sync1;
    end
  end

  // Decode stage: load a new value only when enabled and the synchronized
  // code differs from the last accepted one; the valid pulse lasts one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_gray <= {WIDTH{1'b0}};
      r_bin       <= {WIDTH{1'b0}};
      r_step      <= {WIDTH{1'b0}};
      r_bin_vld   <= 1'b0;
    end else if (w_accept) begin
      r_prev_gray <= r_sync2;
      r_bin       <= w_bin_new;
      r_step      <= w_step;
      r_bin_vld   <= 1'b1;
    end else begin
      r_bin_vld   <= 1'b0;
    end
  end

  // Sticky error flag; a new error on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_multi) begin
      r_err <= 1'b1;
    end else if (clr_err_i) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  assign bin_o     = r_bin;
  assign bin_vld_o = r_bin_vld;
  assign step_o    = r_step;
  assign err_o     = r_err;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Self-checking bench for gray_rx_decoder: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_gray_rx_decoder;

  localparam int WIDTH = 6;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] gray_i;
  logic             en_i;
  logic             clr_err_i;
  logic [WIDTH-1:0] bin_o;
  logic             bin_vld_o;
  logic [WIDTH-1:0] step_o;
  logic             err_o;

  int n_vec;
  int n_miscmp;

  // behavioural model state
  int m_pipe[$];   // gray samples still travelling to the decode stage
  int m_prev;
  int m_bin;
  int m_step;
  int m_vld;
  int m_err;

  gray_rx_decoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .gray_i    (gray_i),
    .en_i      (en_i),
    .clr_err_i (clr_err_i),
    .bin_o     (bin_o),
    .bin_vld_o (bin_vld_o),
    .step_o    (step_o),
    .err_o     (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // gray -> binary as a running XOR of right shifts
  function automatic int g2b(input int g);
    int b;
    b = 0;
    while (g != 0) begin
      b = b ^ g;
      g = g >> 1;
    end
    return b;
  endfunction

  function automatic int b2g(input int b);
    return (b ^ (b >> 1)) & MASK;
  endfunction

  task automatic model_reset();
    m_pipe = {0, 0};
    m_prev = 0;
    m_bin  = 0;
    m_step = 0;
    m_vld  = 0;
    m_err  = 0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    int seen;
    seen = m_pipe.pop_front();
    m_pipe.push_back(int'(gray_i));
    if (en_i && seen != m_prev) begin
      if ($countones(seen ^ m_prev) > 1) m_err = 1;
      else if (clr_err_i) m_err = 0;
      m_step = (g2b(seen) - m_bin) & MASK;
      m_bin  = g2b(seen);
      m_prev = seen;
      m_vld  = 1;
    end else begin
      if (clr_err_i) m_err = 0;
      m_vld = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin"},  int'(bin_o),     m_bin);
    chk({tag, ".vld"},  int'(bin_vld_o), m_vld);
    chk({tag, ".step"}, int'(step_o),    m_step);
    chk({tag, ".err"},  int'(err_o),     m_err);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    repeat (2) @(posedge clk);
    #1;
    check_all({tag, ".held"});
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_miscmp  = 0;
    reset_n   = 1'b0;
    gray_i    = 6'h15;
    en_i      = 1'b1;
    clr_err_i = 1'b0;
    model_reset();

    // reset with a non-zero code waiting, then release
    do_reset("rst");
    repeat (3) tick("rel");
    chk("rel.bin19", int'(bin_o), 32'h19);

    // single step from 0
    gray_i = 6'h00;
    do_reset("rst2");
    gray_i = 6'h01;
    repeat (3) tick("step1");
    chk("step1.bin", int'(bin_o), 1);
    chk("step1.vld", int'(bin_vld_o), 1);
    tick("step1.after");
    chk("step1.pulse", int'(bin_vld_o), 0);

    // wrap-around path 62 -> 63 -> 0
    gray_i = 6'h21;
    repeat (4) tick("wrap62");
    chk("wrap.62", int'(bin_o), 62);
    gray_i = 6'h20;
    repeat (4) tick("wrap63");
    chk("wrap.63", int'(bin_o), 63);
    gray_i = 6'h00;
    repeat (4) tick("wrap0");
    chk("wrap.0", int'(bin_o), 0);
    chk("wrap.step", int'(step_o), 1);
    chk("wrap.err", int'(err_o), 0);

    // multi-bit jump, sticky error, clear, clear colliding with a new error
    gray_i = 6'h03;
    repeat (4) tick("jump");
    chk("jump.bin", int'(bin_o), 2);
    chk("jump.step", int'(step_o), 2);
    chk("jump.err", int'(err_o), 1);
    clr_err_i = 1'b1;
    tick("clr");
    chk("clr.err", int'(err_o), 0);
    clr_err_i = 1'b0;
    gray_i = 6'h00;
    tick("coll1");
    tick("coll2");
    clr_err_i = 1'b1;
    tick("coll3");
    chk("coll.err", int'(err_o), 1);
    clr_err_i = 1'b0;

    // updates held off while disabled, then collapsed into one
    do_reset("rst3");
    en_i   = 1'b0;
    gray_i = 6'h01; repeat (3) tick("dis");
    gray_i = 6'h03; repeat (3) tick("dis");
    gray_i = 6'h02; repeat (3) tick("dis");
    en_i = 1'b1;
    tick("reen");
    chk("reen.bin", int'(bin_o), 3);
    chk("reen.step", int'(step_o), 3);
    chk("reen.err", int'(err_o), 0);
    chk("reen.vld", int'(bin_vld_o), 1);

    // reset in the middle of a transition
    do_reset("rst4");
    gray_i = 6'h07;
    tick("mid");
    do_reset("midrst");
    repeat (2) tick("mid.rel");
    chk("mid.novld", int'(bin_vld_o), 0);
    tick("mid.rel3");
    chk("mid.bin5", int'(bin_o), 5);
    chk("mid.vld", int'(bin_vld_o), 1);

    // randomized traffic
    begin
      int cnt;
      int r;
      cnt = 5;
      for (int i = 0; i < 3000; i++) begin
        r = $urandom_range(0, 99);
        if (r < 20) cnt = (cnt + 1) & MASK;
        else if (r < 28) cnt = (cnt - 1) & MASK;
        else if (r < 33) cnt = $urandom_range(0, MASK);
        gray_i    = b2g(cnt);
        en_i      = ($urandom_range(0, 99) < 80);
        clr_err_i = ($urandom_range(0, 99) < 8);
        if ($urandom_range(0, 999) < 5) begin
          do_reset("rnd.rst");
        end else begin
          tick("rnd");
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
